audio_dac_player: RTL and testbench

//  Stage downstream of the mixing core. Accepts mixed 32-bit stereo samples over valid/ready,

---
 rtl/audio_dac_player.sv | 166 ++++++++++++++++
 tb/tb_audio_dac_player.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_player.sv
// audio_dac_player: buffers {left,right} samples in a small FIFO and sends them to a WM8731 as I2S data.
// Build macro AUDIO_HOLD_LAST_EN: on underflow, repeat the previous frame instead of sending silence.
module audio_dac_player #(
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_play,
    input  logic                          in_valid,
    input  logic [2*CH_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          i_aud_bclk,
    input  logic                          i_aud_daclrck,
    output logic                          o_aud_dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underflow,
    output logic [1:0]                    dbg_state
);

    localparam int DATA_W = 2 * CH_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W  = $clog2(CH_W + 1);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_LEFT      = 2'd1,
        ST_RIGHT     = 2'd2
    } state_t;

    state_t state;

    // Codec clocks: two-flop synchronisers plus one history flop for edge detection.
    logic bclk_s1, bclk_s2, bclk_h;
    logic lrck_s1, lrck_s2, lrck_h;
    logic bclk_fall, lrck_fall, lrck_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_h  <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            lrck_h  <= 1'b0;
        end else begin
            bclk_s1 <= i_aud_bclk;
            bclk_s2 <= bclk_s1;
            bclk_h  <= bclk_s2;
            lrck_s1 <= i_aud_daclrck;
            lrck_s2 <= lrck_s1;
            lrck_h  <= lrck_s2;
        end
    end

    assign bclk_fall = bclk_h & ~bclk_s2;
    assign lrck_fall = lrck_h & ~lrck_s2;
    assign lrck_rise = ~lrck_h & lrck_s2;

    // Input handshake: a sample moves on every i_clk edge where in_valid && in_ready;
    // in_valid/in_data must hold until accepted, in_ready is a registered "not full".
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              push, pop, fifo_empty;

    assign fifo_empty = (o_level == '0);
    assign push       = in_valid && in_ready;
    assign pop        = lrck_fall && i_play && !fifo_empty;

    always_comb begin
        level_next = o_level;
        if (push && !pop) begin
            level_next = o_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = o_level - LVL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_level  <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_level  <= level_next;
            in_ready <= (level_next != LVL_W'(FIFO_DEPTH));
        end
    end

    logic [DATA_W-1:0] frame_q, frame_next;
    logic              underflow_now;

    // Frame latched at the start of each left channel; pause always yields silence.
    always_comb begin
        frame_next    = '0;
        underflow_now = 1'b0;
        if (i_play) begin
            if (!fifo_empty) begin
                frame_next = mem[rd_ptr];
            end else begin
                underflow_now = 1'b1;
`ifdef AUDIO_HOLD_LAST_EN
                frame_next = frame_q;
`else
                frame_next = '0;
`endif
            end
        end
    end

    logic [CH_W-1:0]  shift_q;
    logic [CNT_W-1:0] bit_cnt;

    // LRCK edges take priority over a coincident BCLK fall, which therefore shifts nothing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_WAIT_SYNC;
            frame_q      <= '0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            o_aud_dacdat <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            o_underflow <= 1'b0;
            if (lrck_fall) begin
                state       <= ST_LEFT;
                frame_q     <= frame_next;
                shift_q     <= frame_next[DATA_W-1:CH_W];
                bit_cnt     <= '0;
                o_underflow <= underflow_now;
            end else if (lrck_rise) begin
                if (state == ST_LEFT) begin
                    state   <= ST_RIGHT;
                    shift_q <= frame_q[CH_W-1:0];
                    bit_cnt <= '0;
                end
            end else if (bclk_fall && state != ST_WAIT_SYNC) begin
                if (bit_cnt < CNT_W'(CH_W)) begin
                    o_aud_dacdat <= shift_q[CH_W-1];
                    shift_q      <= {shift_q[CH_W-2:0], 1'b0};
                    bit_cnt      <= bit_cnt + CNT_W'(1);
                end else begin
                    o_aud_dacdat <= 1'b0;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_audio_dac_player.sv
// Directed + randomized bench for audio_dac_player: bench drives codec clocks, captures DACDAT on BCLK rise.
`timescale 1ns/1ps
module tb_audio_dac_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        play;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic [3:0]  level;
    logic        underflow;
    logic [1:0]  dbg_state;

    int          errors = 0;
    int          checks = 0;
    int          uf_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_frame = '0;
    logic        prev_tail = 1'b0;
    bit          stop_drv = 1'b0;

    int          uf0, n7, npush;
    logic [31:0] f, w9, wr;
    bit          uf;
    logic        s, silent;

    audio_dac_player #(.FIFO_DEPTH(8), .CH_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_play       (play),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .i_aud_bclk   (aud_bclk),
        .i_aud_daclrck(aud_daclrck),
        .o_aud_dacdat (aud_dacdat),
        .o_level      (level),
        .o_underflow  (underflow),
        .dbg_state    (dbg_state)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (underflow === 1'b1) uf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: one frame per LRCK period, oldest accepted sample first; silence on pause.
    task automatic next_expected(output logic [31:0] fr, output bit is_uf);
        is_uf = 1'b0;
        if (!play) begin
            fr = '0;
        end else if (exp_q.size() == 0) begin
            is_uf = 1'b1;
`ifdef AUDIO_HOLD_LAST_EN
            fr = last_frame;
`else
            fr = '0;
`endif
        end else begin
            fr = exp_q.pop_front();
        end
        last_frame = fr;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        if (in_ready) exp_q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One BCLK period of 8 i_clk cycles, starting with a fall; LRCK changes with that fall.
    task automatic bclk_period(input logic lr, output logic smp);
        aud_daclrck = lr;
        aud_bclk    = 1'b0;
        repeat (4) @(negedge clk);
        smp      = aud_dacdat;
        aud_bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic channel(input logic lr, input int n, output logic [15:0] word,
                           output logic s0, output logic extra);
        logic smp;
        word  = '0;
        s0    = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < n; i++) begin
            bclk_period(lr, smp);
            if (i == 0)       s0 = smp;
            else if (i <= 16) word = {word[14:0], smp};
            else              extra = extra | smp;
        end
    endtask

    // Slot 0 still shows the previous channel's last bit; slots 1..16 carry the word MSB first.
    task automatic check_channel(input string tag, input logic lr, input int n, input logic [15:0] w);
        logic [15:0] got;
        logic        s0, extra;
        int          e;
        channel(lr, n, got, s0, extra);
        e = (n - 1 > 16) ? 16 : n - 1;
        check({tag, " s0"}, {31'd0, s0}, {31'd0, prev_tail});
        check({tag, " bits"}, {16'd0, got}, {16'd0, w >> (16 - e)});
        check({tag, " tail"}, {31'd0, extra}, 32'd0);
        prev_tail = (n - 1 > 16) ? 1'b0 : w[16 - e];
    endtask

    task automatic run_frame(input int nl, input int nr, input logic [31:0] fr);
        check_channel("left", 1'b0, nl, fr[31:16]);
        check_channel("right", 1'b1, nr, fr[15:0]);
    endtask

    initial begin
        rst         = 1'b1;
        play        = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        aud_bclk    = 1'b1;
        aud_daclrck = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst level", level, 0);
        check("rst in_ready", in_ready, 0);
        check("rst dacdat", aud_dacdat, 0);
        check("rst underflow", underflow, 0);
        check("rst state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after rst", in_ready, 1);

        // Fill with codec idle
        push(32'hA5A5_0F0F);
        for (int i = 0; i < 7; i++) push($urandom);
        check("full in_ready", in_ready, 0);
        check("full level", level, 8);
        check("idle dacdat", aud_dacdat, 0);
        push($urandom);
        check("no push when full", level, exp_q.size());

        // Known pattern at 32 BCLK per channel, then drain with random lengths
        uf0 = uf_cnt;
        next_expected(f, uf);
        run_frame(32, 32, f);
        check("level after pop", level, 7);
        check("ready after pop", in_ready, 1);
        for (int i = 0; i < 7; i++) begin
            next_expected(f, uf);
            run_frame($urandom_range(17, 20), $urandom_range(17, 20), f);
        end
        check("drained level", level, 0);
        check("no underflow yet", uf_cnt - uf0, 0);

        // Underflow
        uf0 = uf_cnt;
        next_expected(f, uf);
        run_frame(20, 20, f);
        check("underflow pulses", uf_cnt - uf0, uf ? 1 : 0);
        check("underflow level", level, 0);

        // Pause keeps the FIFO and outputs silence
        for (int i = 0; i < 3; i++) push($urandom);
        play = 1'b0;
        uf0  = uf_cnt;
        for (int i = 0; i < 2; i++) begin
            next_expected(f, uf);
            run_frame(18, 18, f);
        end
        check("pause level", level, 3);
        check("pause no underflow", uf_cnt - uf0, 0);
        play = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_expected(f, uf);
            run_frame(18, 17, f);
        end
        check("resume level", level, 0);

        // Full FIFO with in_valid held across a pop
        for (int i = 0; i < 8; i++) push($urandom);
        w9       = $urandom;
        in_valid = 1'b1;
        in_data  = w9;
        n7       = 0;
        npush    = 0;
        next_expected(f, uf);
        fork
            run_frame(20, 20, f);
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (in_valid && in_ready) begin
                        exp_q.push_back(w9);
                        npush++;
                    end
                    if (level == 4'd7) n7++;
                end
                in_valid = 1'b0;
            end
        join
        check("one refill push", npush, 1);
        check("cycles at level 7", n7, 1);
        check("refilled level", level, 8);
        check("refilled ready", in_ready, 0);

        // Random stream against the scoreboard, including short channels
        uf0      = uf_cnt;
        stop_drv = 1'b0;
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    next_expected(f, uf);
                    run_frame($urandom_range(12, 20), $urandom_range(12, 20), f);
                end
                stop_drv = 1'b1;
            end
            begin
                while (!stop_drv) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data  = $urandom;
                    if (in_valid && in_ready) exp_q.push_back(in_data);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
        join
        @(negedge clk);
        check("stream level", level, exp_q.size());
        check("stream no underflow", uf_cnt - uf0, 0);

        // Reset in the middle of a left channel
        for (int i = 0; i < 5; i++) bclk_period(1'b0, s);
        rst = 1'b1;
        #1;
        check("async rst dacdat", aud_dacdat, 0);
        check("async rst level", level, 0);
        check("async rst ready", in_ready, 0);
        for (int i = 0; i < 2; i++) bclk_period(1'b0, s);
        rst = 1'b0;
        exp_q.delete();
        last_frame = '0;
        prev_tail  = 1'b0;
        @(negedge clk);
        check("ready after mid rst", in_ready, 1);
        wr = $urandom;
        push(wr);
        silent = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bclk_period(1'b0, s);
            silent = silent | s;
        end
        for (int i = 0; i < 20; i++) begin
            bclk_period(1'b1, s);
            silent = silent | s;
        end
        check("silent until lrck fall", silent, 0);
        check("no pop before sync", level, 1);
        next_expected(f, uf);
        run_frame(20, 20, f);
        check("post rst level", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
